switch_move_conditioner: RTL and testbench



---
 rtl/switch_move_conditioner_pkg.sv | 29 ++
 rtl/switch_move_conditioner_channel.sv | 122 ++++++++++++
 rtl/switch_move_conditioner.sv | 96 +++++++++
 tb/tb_switch_move_conditioner.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/switch_move_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// switch_move_conditioner_pkg
//   Shared definitions for the switch move conditioner:
//     - chan_state_t : per-channel press/repeat FSM encoding
//     - default timing constants (25 MHz clock)
//     - channel ordering within the 4-bit vectors used by the top level
// -----------------------------------------------------------------------------
package switch_move_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } chan_state_t;

    // 10 ms debounce, 300 ms first repeat, 150 ms repeat period at 25 MHz.
    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_REPEAT_DELAY    = 7500000;
    localparam int DEFAULT_REPEAT_PERIOD   = 3750000;

    localparam int NUM_SWITCHES = 4;

    // Bit positions inside the {right,left,down,up} vectors.
    localparam int CH_UP    = 0;
    localparam int CH_DOWN  = 1;
    localparam int CH_LEFT  = 2;
    localparam int CH_RIGHT = 3;

endpackage

// File: rtl/switch_move_conditioner_channel.sv
// -----------------------------------------------------------------------------
// switch_channel
//   One switch lane: 2-flop synchroniser, counting debouncer and the
//   press / auto-repeat FSM.
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous active-high reset
//     raw    in   raw asynchronous switch level (active-high)
//     pulse  out  combinational request, one cycle wide; the top level
//                 registers it, so it must not be used unregistered elsewhere
//     level  out  debounced (stable) switch level
// -----------------------------------------------------------------------------
module switch_channel
    import switch_move_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    // Guard against zero-width vectors for degenerate parameter values.
    localparam int DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TM_W = (REPEAT_DELAY > 1)    ? $clog2(REPEAT_DELAY)        : 1;

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TM_W-1:0] DELAY_LOAD  = TM_W'(REPEAT_DELAY - 1);
    localparam logic [TM_W-1:0] PERIOD_LOAD = TM_W'(REPEAT_PERIOD - 1);

    // -------------------------------------------------------------------------
    // Synchroniser: sync_reg[1] is the only view of the switch used below.
    // -------------------------------------------------------------------------
    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw};
        end
    end

    // -------------------------------------------------------------------------
    // Debouncer: the synchronised level must differ from the accepted level
    // for DEBOUNCE_CYCLES consecutive cycles before it is accepted. Any cycle
    // where they agree (e.g. a one-cycle glitch ending) restarts the count.
    // -------------------------------------------------------------------------
    logic [DB_W-1:0] db_cnt_reg;
    logic            stable_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_reg <= '0;
            stable_reg <= 1'b0;
        end else if (sync_reg[1] == stable_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
            stable_reg <= sync_reg[1];
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    assign level = stable_reg;

    // -------------------------------------------------------------------------
    // Press / repeat FSM.
    // IDLE is only entered from reset or on release, where stable is 0, so
    // "stable high while IDLE" is exactly a 0->1 edge of the debounced level.
    // A switch held through reset therefore counts as a fresh press.
    // -------------------------------------------------------------------------
    chan_state_t     state_reg, state_next;
    logic [TM_W-1:0] timer_reg, timer_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        pulse      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (stable_reg) begin
                    pulse      = 1'b1;
                    timer_next = DELAY_LOAD;
                    state_next = HOLD;
                end
            end
            HOLD, REPEAT: begin
                // Release wins over an expiring timer in the same cycle.
                if (!stable_reg) begin
                    state_next = IDLE;
                end else if (timer_reg == '0) begin
                    pulse      = 1'b1;
                    timer_next = PERIOD_LOAD;
                    state_next = REPEAT;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/switch_move_conditioner.sv
// -----------------------------------------------------------------------------
// switch_move_conditioner
//   Turns the four raw board switches into clean one-cycle move requests for
//   the frog position logic, with debounce and auto-repeat while held.
//   Contradictory pairs (up+down, left+right) are suppressed while both
//   debounced levels are high; perpendicular pairs pass through.
//
//   Ports:
//     clk         in   system clock (25 MHz)
//     reset       in   asynchronous active-high reset
//     switch1..4  in   raw switches: up, down, left, right (active-high)
//     move_up     out  one-cycle move request
//     move_down   out  one-cycle move request
//     move_left   out  one-cycle move request
//     move_right  out  one-cycle move request
//     held        out  registered debounced levels {right,left,down,up}
// -----------------------------------------------------------------------------
module switch_move_conditioner
    import switch_move_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       switch3,
    input  logic       switch4,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [3:0] held
);

    logic [NUM_SWITCHES-1:0] raw;
    logic [NUM_SWITCHES-1:0] pulse;
    logic [NUM_SWITCHES-1:0] level;
    logic [NUM_SWITCHES-1:0] move_next;
    logic [NUM_SWITCHES-1:0] move_reg;
    logic [NUM_SWITCHES-1:0] held_reg;

    assign raw = {switch4, switch3, switch2, switch1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SWITCHES; gi++) begin : g_chan
            switch_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk   (clk),
                .reset (reset),
                .raw   (raw[gi]),
                .pulse (pulse[gi]),
                .level (level[gi])
            );
        end
    endgenerate

    // The mask is evaluated on the same debounced levels that are being
    // registered into held, so a move output and the held value visible in
    // the same cycle always agree. Masked pulses are simply dropped; the
    // channel FSMs keep their own schedule.
    always_comb begin
        move_next = pulse;
        if (level[CH_UP] && level[CH_DOWN]) begin
            move_next[CH_UP]   = 1'b0;
            move_next[CH_DOWN] = 1'b0;
        end
        if (level[CH_LEFT] && level[CH_RIGHT]) begin
            move_next[CH_LEFT]  = 1'b0;
            move_next[CH_RIGHT] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            move_reg <= '0;
            held_reg <= '0;
        end else begin
            move_reg <= move_next;
            held_reg <= level;
        end
    end

    assign move_up    = move_reg[CH_UP];
    assign move_down  = move_reg[CH_DOWN];
    assign move_left  = move_reg[CH_LEFT];
    assign move_right = move_reg[CH_RIGHT];
    assign held       = held_reg;

endmodule

// File: tb/tb_switch_move_conditioner.sv
// -----------------------------------------------------------------------------
// tb_switch_move_conditioner
//   Directed bench with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
//   Cycle numbering: cycle c is the interval just after rising edge c, where
//   edge 0 is the first edge after reset release. Inputs change and outputs
//   are sampled 1 time unit after the edge. A press starting in cycle 0
//   yields pulses in cycles 7, 17, 22, 27, ...
// -----------------------------------------------------------------------------
module tb_switch_move_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;          // {right,left,down,up} = {switch4..switch1}
    logic       move_up, move_down, move_left, move_right;
    logic [3:0] held;
    logic [3:0] mv;

    always #5 clk = ~clk;

    assign mv = {move_right, move_left, move_down, move_up};

    switch_move_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .switch1    (sw[0]),
        .switch2    (sw[1]),
        .switch3    (sw[2]),
        .switch4    (sw[3]),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right),
        .held       (held)
    );

    typedef struct {
        string       name;
        logic [3:0]  sw;         // pattern applied from cycle 0
        int          hold;       // switches drop to 0 from this cycle on
        int          run;        // last cycle checked
        logic [39:0] exp_up;     // bit c set: pulse expected in cycle c
        logic [39:0] exp_down;
        logic [39:0] exp_left;
        logic [39:0] exp_right;
        logic [3:0]  exp_held;   // held expected in the last cycle
    } vec_t;

    vec_t vecs[8];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    localparam logic [39:0] ONE = 40'd1;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Leaves the bench at cycle 0 with reset just released.
    task automatic do_reset();
        reset = 1'b1;
        sw    = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_moves", mv, 4'b0000);
        check("reset_held", held, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    function automatic logic [3:0] sched(input int c, input logic [3:0] chans);
        // Single-press schedule from a cycle-0 press, limited to given lanes.
        if (c == 7 || c == 17 || (c >= 22 && (c - 22) % 5 == 0))
            return chans;
        return 4'b0000;
    endfunction

    initial begin
        reset = 1'b1;
        sw    = 4'b0000;

        vecs[0] = '{"short_glitch",   4'b0001, 3,   14, 40'd0, 40'd0, 40'd0, 40'd0, 4'b0000};
        vecs[1] = '{"exact_debounce", 4'b0001, 4,   14, ONE << 7, 40'd0, 40'd0, 40'd0, 4'b0000};
        vecs[2] = '{"up_repeat",      4'b0001, 999, 29,
                    (ONE << 7) | (ONE << 17) | (ONE << 22) | (ONE << 27),
                    40'd0, 40'd0, 40'd0, 4'b0001};
        vecs[3] = '{"up_left",        4'b0101, 999, 24,
                    (ONE << 7) | (ONE << 17) | (ONE << 22), 40'd0,
                    (ONE << 7) | (ONE << 17) | (ONE << 22), 40'd0, 4'b0101};
        vecs[4] = '{"up_down_masked", 4'b0011, 999, 29, 40'd0, 40'd0, 40'd0, 40'd0, 4'b0011};
        vecs[5] = '{"lr_masked",      4'b1100, 999, 29, 40'd0, 40'd0, 40'd0, 40'd0, 4'b1100};
        vecs[6] = '{"down_release",   4'b0010, 10,  29, 40'd0, ONE << 7, 40'd0, 40'd0, 4'b0000};
        vecs[7] = '{"right_repeat",   4'b1000, 999, 24, 40'd0, 40'd0, 40'd0,
                    (ONE << 7) | (ONE << 17) | (ONE << 22), 4'b1000};

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 8; v++) begin
            do_reset();
            sw = vecs[v].sw;
            check({vecs[v].name, "_c0"}, mv, 4'b0000);
            while (cyc < vecs[v].run) begin
                step();
                if (cyc >= vecs[v].hold) sw = 4'b0000;
                check(vecs[v].name, mv,
                      {vecs[v].exp_right[cyc], vecs[v].exp_left[cyc],
                       vecs[v].exp_down[cyc], vecs[v].exp_up[cyc]});
            end
            check({vecs[v].name, "_held"}, held, vecs[v].exp_held);
        end

        // ---------------- bouncing left switch ----------------
        // Toggles every 2 cycles for cycles 0..19, then high from cycle 20.
        do_reset();
        sw = 4'b0100;
        while (cyc < 35) begin
            step();
            if (cyc < 20) sw[2] = ((cyc / 2) % 2 == 0);
            else          sw[2] = 1'b1;
            check("bounce_left", mv, (cyc == 27) ? 4'b0100 : 4'b0000);
        end

        // ---------------- up+down, then release down ----------------
        do_reset();
        sw = 4'b0011;
        while (cyc < 28) begin
            step();
            if (cyc == 19) begin
                check("ud_held_both", held, 4'b0011);
                sw = 4'b0001;
            end
            if (cyc == 24) check("ud_held_before", held, 4'b0011);
            if (cyc == 26) check("ud_held_after", held, 4'b0001);
            check("ud_release", mv, (cyc == 27) ? 4'b0001 : 4'b0000);
        end

        // ---------------- reset during REPEAT with right held ----------------
        do_reset();
        sw = 4'b1000;
        while (cyc < 22) begin
            step();
            check("rst_pre", mv, sched(cyc, 4'b1000));
        end
        #1;
        reset = 1'b1;
        #1;
        check("rst_async_moves", mv, 4'b0000);
        check("rst_async_held", held, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 0;
        while (cyc < 23) begin
            step();
            check("rst_post", mv, sched(cyc, 4'b1000));
        end

        // ---------------- release in HOLD, then press again ----------------
        // Debounced release lands exactly when the first repeat would fire.
        do_reset();
        sw = 4'b0010;
        while (cyc < 40) begin
            step();
            if (cyc == 10) sw = 4'b0000;
            if (cyc == 30) sw = 4'b0010;
            check("repress_down", mv, (cyc == 7 || cyc == 37) ? 4'b0010 : 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
